// File: rtl/canvas_pkg.sv
// canvas_pkg: shared opcodes, FSM states and geometry for the canvas command controller
package canvas_pkg;
   localparam int CANVAS_PIX_DEF = 1024;
   localparam int ADDR_W = 10;
   localparam int COLOR_W = 4;
   localparam int STARVE_LIMIT = 4;
   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_SET_CURSOR = 3'd1;
   localparam logic [2:0] OP_PIXEL = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_CLEAR = 3'd4;
   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FILL} state_t;
   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a, input int pix);
      return (a == ADDR_W'(pix - 1)) ? '0 : a + ADDR_W'(1);
   endfunction
endpackage

// File: rtl/canvas_mem_arb.sv
// canvas_mem_arb: scanout-priority 2:1 RAM arbiter with a write starvation guard
module canvas_mem_arb
   import canvas_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               scan_req,
   input  logic [ADDR_W-1:0]  scan_addr,
   output logic               scan_gnt,
   output logic               scan_rvalid,
   output logic [COLOR_W-1:0] scan_rdata,
   input  logic               wr_req,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [COLOR_W-1:0] wr_data,
   output logic               wr_gnt,
   output logic               mem_en,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [COLOR_W-1:0] mem_wdata,
   input  logic [COLOR_W-1:0] mem_rdata
);
   logic [2:0] starve_cnt;
   assign wr_gnt = rst_n && wr_req && (!scan_req || starve_cnt == 3'(STARVE_LIMIT));
   assign scan_gnt = rst_n && scan_req && !wr_gnt;
   assign mem_en = scan_gnt || wr_gnt;
   assign mem_we = wr_gnt;
   assign mem_addr = wr_gnt ? wr_addr : scan_addr;
   assign mem_wdata = wr_data;
   assign scan_rdata = mem_rdata;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         scan_rvalid <= 1'b0;
      end else begin
         starve_cnt <= (wr_gnt || !wr_req) ? '0 : scan_gnt ? starve_cnt + 3'd1 : starve_cnt;
         scan_rvalid <= scan_gnt;
      end
   end
endmodule

// File: rtl/canvas_cmd_ctrl.sv
// canvas_cmd_ctrl: toggle-strobed drawing command FSM writing a pixel RAM shared with scanout
module canvas_cmd_ctrl
   import canvas_pkg::*;
#(
   parameter int CANVAS_PIX = CANVAS_PIX_DEF
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_n,
   input  logic [31:0]        la1_data_in,
   output logic [31:0]        la1_data_out,
   input  logic               scan_req,
   input  logic [ADDR_W-1:0]  scan_addr,
   output logic               scan_gnt,
   output logic               scan_rvalid,
   output logic [COLOR_W-1:0] scan_rdata,
   output logic               mem_en,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [COLOR_W-1:0] mem_wdata,
   input  logic [COLOR_W-1:0] mem_rdata
);
   state_t state;
   logic [ADDR_W-1:0] cursor, count;
   logic [COLOR_W-1:0] color;
   logic tog, ack, pend, overrun, wr_gnt, cmd_edge, busy, err_inc, unused_bits;
   logic [7:0] err_cnt;
   logic [2:0] op;
   logic [ADDR_W-1:0] arg;
   assign op = la1_data_in[30:28];
   assign arg = la1_data_in[25:16];
   assign unused_bits = ^{la1_data_in[27:26], la1_data_in[15:4]};
   assign cmd_edge = la1_data_in[31] ^ tog;
   assign busy = state != ST_IDLE;
   assign err_inc = cmd_edge && (busy || op > OP_CLEAR);
   assign la1_data_out = {ack, busy, overrun, 5'd0, err_cnt, 6'd0, cursor};
   canvas_mem_arb u_arb (
      .clk(wb_clk_i), .rst_n(wb_rst_n),
      .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
      .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
      .wr_req(busy), .wr_addr(cursor), .wr_data(color), .wr_gnt(wr_gnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= ST_IDLE;
         cursor <= '0;
         count <= '0;
         color <= '0;
         tog <= 1'b0;
         ack <= 1'b0;
         pend <= 1'b0;
         overrun <= 1'b0;
         err_cnt <= '0;
      end else begin
         tog <= la1_data_in[31];
         if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (cmd_edge && busy) overrun <= 1'b1;
         if (state == ST_IDLE) begin
            if (cmd_edge) begin
               pend <= la1_data_in[31];
               color <= la1_data_in[COLOR_W-1:0];
               case (op)
                  OP_SET_CURSOR: begin
                     cursor <= arg;
                     ack <= la1_data_in[31];
                  end
                  OP_PIXEL: state <= ST_WRITE;
                  OP_FILL: begin
                     count <= arg;
                     state <= ST_FILL;
                  end
                  OP_CLEAR: begin
                     cursor <= '0;
                     count <= ADDR_W'(CANVAS_PIX - 1);
                     state <= ST_FILL;
                  end
                  default: ack <= la1_data_in[31];
               endcase
            end
         end else if (wr_gnt) begin
            // count holds pixels remaining minus one, so zero marks the last write
            cursor <= wrap_inc(cursor, CANVAS_PIX);
            count <= count - ADDR_W'(1);
            if (state == ST_WRITE || count == '0) begin
               ack <= pend;
               state <= ST_IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_canvas_cmd_ctrl.sv
// tb_canvas_cmd_ctrl: randomized self-checking bench with a behavioural canvas model
module tb_canvas_cmd_ctrl;
   import canvas_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] la1_data_in = '0;
   logic [31:0] la1_data_out;
   logic scan_req = 1'b0;
   logic [9:0] scan_addr = '0;
   logic scan_gnt, scan_rvalid, mem_en, mem_we;
   logic [3:0] scan_rdata, mem_wdata;
   logic [3:0] mem_rdata;
   logic [9:0] mem_addr;
   logic [3:0] ram [1024];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [13:0] wq[$];
   int wcyc[$];
   logic prev_gnt = 1'b0;
   logic [3:0] exp_rd = '0;
   logic tog_val = 1'b0;
   logic exp_ack = 1'b0;
   logic exp_ovr = 1'b0;
   logic [9:0] exp_cursor = '0;
   int exp_err = 0;

   always #5 clk = ~clk;

   canvas_cmd_ctrl dut (
      .wb_clk_i(clk), .wb_rst_n(rst_n), .la1_data_in(la1_data_in), .la1_data_out(la1_data_out),
      .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt), .scan_rvalid(scan_rvalid),
      .scan_rdata(scan_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
   end

   // Values seen at negedge are the accesses committed by the following posedge
   always @(negedge clk) begin
      if (!rst_n) prev_gnt = 1'b0;
      else begin
         checks++;
         if (scan_rvalid !== prev_gnt) begin
            errors++;
            $display("FAIL rvalid_timing: got %b exp %b", scan_rvalid, prev_gnt);
         end
         if (prev_gnt) begin
            checks++;
            if (scan_rdata !== exp_rd) begin
               errors++;
               $display("FAIL scan_rdata: got %h exp %h", scan_rdata, exp_rd);
            end
         end
         if (mem_we && (!mem_en || scan_gnt)) begin
            errors++;
            $display("FAIL one_access: mem_en %b mem_we %b scan_gnt %b", mem_en, mem_we, scan_gnt);
         end
         if (mem_en && mem_we) begin
            wq.push_back({mem_addr, mem_wdata});
            wcyc.push_back(cyc);
         end
         prev_gnt = scan_gnt;
         exp_rd = ram[scan_addr];
      end
   end

   function automatic logic [31:0] exp_status();
      return {exp_ack, 1'b0, exp_ovr, 5'd0, 8'(exp_err), 6'd0, exp_cursor};
   endfunction

   function automatic void bump_err();
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [9:0] arg, input logic [3:0] col);
      tog_val = ~tog_val;
      la1_data_in = {tog_val, op, 2'($urandom), arg, 12'($urandom), col};
      tick();
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (la1_data_out[30] && n < budget) begin
         tick();
         n++;
      end
      if (la1_data_out[30]) begin
         errors++;
         checks++;
         $display("FAIL wait_idle: still busy after %0d cycles", n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      scan_req = 1'b1;
      scan_addr = 10'h123;
      la1_data_in = '0;
      repeat (3) tick();
      checks++;
      if ({la1_data_out, scan_gnt, scan_rvalid, mem_en, mem_we} !== 36'h0) begin
         errors++;
         $display("FAIL reset_outputs: status %h gnt %b rv %b en %b we %b", la1_data_out, scan_gnt, scan_rvalid, mem_en, mem_we);
      end
      rst_n = 1'b1;
      scan_req = 1'b0;
      tick();
      checks++;
      if (la1_data_out !== exp_status()) begin
         errors++;
         $display("FAIL reset_status: got %h exp %h", la1_data_out, exp_status());
      end
   endtask

   task automatic test_pixel();
      int n;
      bit ok;
      send(OP_SET_CURSOR, 10'h3FE, 4'($urandom));
      exp_cursor = 10'h3FE;
      exp_ack = tog_val;
      checks++;
      if (la1_data_out !== exp_status()) begin
         errors++;
         $display("FAIL set_cursor: got %h exp %h", la1_data_out, exp_status());
      end
      wq.delete();
      wcyc.delete();
      for (int i = 0; i < 3; i++) begin
         send(OP_PIXEL, 10'($urandom), 4'd5);
         wait_idle(20, n);
         exp_ack = tog_val;
      end
      ok = wq.size() == 3;
      for (int i = 0; i < 3 && ok; i++) ok = wq[i] == {10'((1022 + i) % 1024), 4'd5};
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL pixel_writes: got %0d writes first %h exp 3 writes from 3fe5", wq.size(), wq.size() > 0 ? wq[0] : 14'h0);
      end
      exp_cursor = 10'h001;
      checks++;
      if (la1_data_out !== exp_status()) begin
         errors++;
         $display("FAIL pixel_status: got %h exp %h", la1_data_out, exp_status());
      end
   endtask

   task automatic test_fill();
      int n, start, cnt;
      logic [3:0] col;
      bit ok;
      for (int it = 0; it < 4; it++) begin
         start = (it == 0) ? 16 : (it == 1) ? int'($urandom_range(1010, 1023)) : int'($urandom_range(0, 1023));
         cnt = (it == 0) ? 9 : int'($urandom_range(0, 24));
         col = (it == 0) ? 4'hA : 4'($urandom);
         send(OP_SET_CURSOR, 10'(start), 4'($urandom));
         exp_cursor = 10'(start);
         exp_ack = tog_val;
         wq.delete();
         wcyc.delete();
         send(OP_FILL, 10'(cnt), col);
         wait_idle(100, n);
         exp_ack = tog_val;
         checks++;
         if (n != cnt + 1) begin
            errors++;
            $display("FAIL fill_busy: got %0d cycles exp %0d", n, cnt + 1);
         end
         ok = wq.size() == cnt + 1;
         for (int k = 0; k <= cnt && ok; k++) ok = wq[k] == {10'((start + k) % 1024), col} && wcyc[k] == wcyc[0] + k;
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL fill_writes: got %0d writes exp %0d from %h color %h", wq.size(), cnt + 1, start, col);
         end
         exp_cursor = 10'((start + cnt + 1) % 1024);
         checks++;
         if (la1_data_out !== exp_status()) begin
            errors++;
            $display("FAIL fill_status: got %h exp %h", la1_data_out, exp_status());
         end
      end
   endtask

   task automatic test_starve();
      int start;
      logic [3:0] col;
      bit exp_w, ok;
      start = int'($urandom_range(0, 1023));
      col = 4'($urandom);
      send(OP_SET_CURSOR, 10'(start), 4'($urandom));
      exp_cursor = 10'(start);
      exp_ack = tog_val;
      wq.delete();
      wcyc.delete();
      scan_req = 1'b1;
      scan_addr = 10'($urandom);
      send(OP_FILL, 10'd11, col);
      for (int k = 0; k < 60; k++) begin
         exp_w = (k % 5) == 4;
         checks++;
         if (scan_gnt !== !exp_w || mem_we !== exp_w) begin
            errors++;
            $display("FAIL starve_pattern: cycle %0d got gnt %b we %b exp gnt %b we %b", k, scan_gnt, mem_we, !exp_w, exp_w);
         end
         scan_addr = 10'($urandom);
         tick();
      end
      scan_req = 1'b0;
      exp_ack = tog_val;
      exp_cursor = 10'((start + 12) % 1024);
      ok = wq.size() == 12;
      for (int k = 0; k < 12 && ok; k++) ok = wq[k] == {10'((start + k) % 1024), col};
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL starve_writes: got %0d writes exp 12 from %h", wq.size(), start);
      end
      checks++;
      if (la1_data_out !== exp_status()) begin
         errors++;
         $display("FAIL starve_status: got %h exp %h", la1_data_out, exp_status());
      end
   endtask

   task automatic test_overrun();
      int n, start;
      logic [3:0] col;
      logic fill_tog;
      bit ok;
      start = int'($urandom_range(0, 1023));
      col = 4'($urandom);
      send(OP_SET_CURSOR, 10'(start), 4'($urandom));
      exp_cursor = 10'(start);
      exp_ack = tog_val;
      wq.delete();
      wcyc.delete();
      send(OP_FILL, 10'd15, col);
      fill_tog = tog_val;
      tick();
      tick();
      send(OP_PIXEL, 10'($urandom), ~col);
      exp_ovr = 1'b1;
      bump_err();
      wait_idle(50, n);
      exp_ack = fill_tog;
      exp_cursor = 10'((start + 16) % 1024);
      ok = wq.size() == 16;
      for (int k = 0; k < 16 && ok; k++) ok = wq[k] == {10'((start + k) % 1024), col};
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL overrun_writes: got %0d writes exp 16 from %h", wq.size(), start);
      end
      checks++;
      if (la1_data_out !== exp_status()) begin
         errors++;
         $display("FAIL overrun_status: got %h exp %h", la1_data_out, exp_status());
      end
   endtask

   task automatic test_illegal();
      logic [2:0] op;
      for (int i = 0; i < 4; i++) begin
         op = (i == 0) ? 3'd6 : (i == 3) ? OP_NOP : 3'($urandom_range(5, 7));
         wq.delete();
         send(op, 10'($urandom), 4'($urandom));
         if (op != OP_NOP) bump_err();
         exp_ack = tog_val;
         checks++;
         if (la1_data_out !== exp_status()) begin
            errors++;
            $display("FAIL illegal_status: op %0d got %h exp %h", op, la1_data_out, exp_status());
         end
         tick();
         tick();
         checks++;
         if (wq.size() != 0) begin
            errors++;
            $display("FAIL illegal_write: op %0d got %0d writes exp 0", op, wq.size());
         end
      end
      for (int i = 0; i < 260; i++) begin
         send(3'd7, 10'($urandom), 4'($urandom));
         bump_err();
      end
      exp_ack = tog_val;
      checks++;
      if (la1_data_out !== exp_status()) begin
         errors++;
         $display("FAIL err_saturate: got %h exp %h", la1_data_out, exp_status());
      end
   endtask

   task automatic test_clear_and_abort();
      int n, nw;
      bit ok;
      wq.delete();
      wcyc.delete();
      send(OP_CLEAR, 10'($urandom), 4'd3);
      wait_idle(1100, n);
      exp_ack = tog_val;
      exp_cursor = '0;
      checks++;
      if (n != 1024) begin
         errors++;
         $display("FAIL clear_busy: got %0d cycles exp 1024", n);
      end
      ok = wq.size() == 1024;
      for (int k = 0; k < 1024 && ok; k++) ok = wq[k] == {10'(k), 4'd3};
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL clear_writes: got %0d writes exp 1024 of color 3", wq.size());
      end
      checks++;
      if (la1_data_out !== exp_status()) begin
         errors++;
         $display("FAIL clear_status: got %h exp %h", la1_data_out, exp_status());
      end
      scan_req = 1'b1;
      scan_addr = 10'h200;
      #1;
      checks++;
      if (scan_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h200) begin
         errors++;
         $display("FAIL scan_grant: gnt %b en %b we %b addr %h exp 1 1 0 200", scan_gnt, mem_en, mem_we, mem_addr);
      end
      tick();
      scan_req = 1'b0;
      checks++;
      if (scan_rvalid !== 1'b1 || scan_rdata !== 4'd3) begin
         errors++;
         $display("FAIL scan_read: rvalid %b data %h exp 1 3", scan_rvalid, scan_rdata);
      end
      send(OP_CLEAR, 10'($urandom), 4'($urandom));
      repeat (5) tick();
      rst_n = 1'b0;
      la1_data_in = {1'b1, OP_SET_CURSOR, 2'b00, 10'h155, 16'h0000};
      #1;
      checks++;
      if ({la1_data_out, mem_en, mem_we, scan_gnt} !== 35'h0) begin
         errors++;
         $display("FAIL reset_abort: status %h en %b we %b gnt %b exp all 0", la1_data_out, mem_en, mem_we, scan_gnt);
      end
      nw = wq.size();
      repeat (3) tick();
      checks++;
      if (wq.size() != nw) begin
         errors++;
         $display("FAIL reset_writes: got %0d writes exp %0d", wq.size(), nw);
      end
      rst_n = 1'b1;
      tog_val = 1'b1;
      exp_ack = 1'b1;
      exp_ovr = 1'b0;
      exp_err = 0;
      exp_cursor = 10'h155;
      tick();
      checks++;
      if (la1_data_out !== exp_status()) begin
         errors++;
         $display("FAIL reset_edge_cmd: got %h exp %h", la1_data_out, exp_status());
      end
   endtask

   initial begin
      test_reset();
      test_pixel();
      test_fill();
      test_starve();
      test_overrun();
      test_illegal();
      test_clear_and_abort();
      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
